// File: rtl/if_stage.sv
// MiniMIPS32 instruction-fetch stage: owns the PC, drives the per-cycle imem request.
// Optional IF_ADDR_EXC_EN adds misaligned-fetch detection (exc_adel / exc_badvaddr).
module if_stage #(
  parameter logic [31:0] PC_INIT = 32'hBFC0_0000,
  parameter int          PC_STEP = 4
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic [3:0]  stall,
  input  logic        flush,
  input  logic [31:0] cp0_excaddr,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  input  logic        iack,
  output logic        ice,
  output logic [31:0] iaddr,
  output logic [31:0] pc,
`ifdef IF_ADDR_EXC_EN
  output logic        exc_adel,
  output logic [31:0] exc_badvaddr,
`endif
  output logic        if_valid,
  output logic        stallreq_if
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {RST, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [31:0] npc;
  logic        misal, advance, to_hold;
  logic        unused_ok;

  assign unused_ok = ^stall[3:1];

  // Redirect targets are word-aligned unless misalignment is reported as an exception.
  function automatic logic [31:0] fix(input logic [31:0] a);
`ifdef IF_ADDR_EXC_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

`ifdef IF_ADDR_EXC_EN
  assign misal        = (state == FETCH) && (pc[1:0] != 2'b00);
  assign exc_adel     = misal;
  assign exc_badvaddr = pc;
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    if (flush)         npc = fix(cp0_excaddr);
    else if (pend_vld) npc = pend_addr;
    else if (jump_flag) npc = fix(jump_addr);
    else               npc = pc + 32'(PC_STEP);
  end

  always_comb begin
    ice         = 1'b0;
    iaddr       = pc;
    if_valid    = 1'b0;
    stallreq_if = 1'b0;
    advance     = 1'b0;
    to_hold     = 1'b0;
    state_nxt   = state;
    case (state)
      RST: state_nxt = FETCH;
      FETCH: begin
        if (!misal) begin
          ice         = 1'b1;
          stallreq_if = ~iack;
          if_valid    = iack;
          advance     = iack && (stall[0] != STOP);
          to_hold     = iack && (stall[0] == STOP);
        end
        if (to_hold) state_nxt = HOLD;
      end
      HOLD: begin
        if_valid = 1'b1;
        advance  = (stall[0] != STOP);
        if (advance) state_nxt = FETCH;
      end
      default: state_nxt = RST;
    endcase
    // A flush redirects this cycle, so nothing here is a completed fetch.
    if (flush) if_valid = 1'b0;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state     <= RST;
      pc        <= PC_INIT;
      pend_vld  <= 1'b0;
      pend_addr <= 32'h0;
    end else if (flush) begin
      state    <= FETCH;
      pc       <= fix(cp0_excaddr);
      pend_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        pc       <= npc;
        pend_vld <= 1'b0;
      end else if (jump_flag && state != RST) begin
        // Delay slot still in flight: remember the target, latest jump wins.
        pend_vld  <= 1'b1;
        pend_addr <= fix(jump_addr);
      end
    end
  end

endmodule
